// File: rtl/matrix_result_ram_pkg.sv
// Shared constants for the matrix result store: default element/address widths
// and the dump sequencer state encoding.
package matrix_result_ram_pkg;

  localparam int DEF_DATA_W = 19;
  localparam int DEF_ADDR_W = 6;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;

endpackage

// File: rtl/matrix_result_ram_core.sv
// Storage array with per-entry valid tags, dual write ports (B wins on a tie)
// and one registered, read-first read port.
module matrix_result_ram_core
  import matrix_result_ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_a,
  input  logic [ADDR_W-1:0]        wr_addr_a,
  input  logic signed [DATA_W-1:0] wr_data_a,
  input  logic                     wr_en_b,
  input  logic [ADDR_W-1:0]        wr_addr_b,
  input  logic signed [DATA_W-1:0] wr_data_b,
  input  logic                     clear,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [DATA_W-1:0] rd_data,
  output logic                     rd_tag,
  output logic                     collision
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic signed [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]         valid;

  // Array kept free of reset so it maps onto block RAM; the later B write
  // overrides A when both target the same entry.
  always_ff @(posedge clk) begin
    if (wr_en_a) mem[wr_addr_a] <= wr_data_a;
    if (wr_en_b) mem[wr_addr_b] <= wr_data_b;
    if (rd_en)   rd_data <= mem[rd_addr];
  end

  // A write in the same cycle as clear leaves its entry valid.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tag
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid[gi] <= 1'b0;
      end else begin
        valid[gi] <= (valid[gi] & ~clear)
                   | (wr_en_a && (wr_addr_a == ADDR_W'(gi)))
                   | (wr_en_b && (wr_addr_b == ADDR_W'(gi)));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_tag    <= 1'b0;
      collision <= 1'b0;
    end else begin
      if (rd_en) rd_tag <= valid[rd_addr];
      collision <= wr_en_a && wr_en_b && (wr_addr_a == wr_addr_b);
    end
  end

endmodule

// File: rtl/matrix_result_ram.sv
// Matrix result store: core storage plus a dump sequencer that shares the
// core read port with the random-read path (dump has priority while busy).
module matrix_result_ram
  import matrix_result_ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_a,
  input  logic [ADDR_W-1:0]        wr_addr_a,
  input  logic signed [DATA_W-1:0] wr_data_a,
  input  logic                     wr_en_b,
  input  logic [ADDR_W-1:0]        wr_addr_b,
  input  logic signed [DATA_W-1:0] wr_data_b,
  input  logic                     clear,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [DATA_W-1:0] rd_data,
  output logic                     rd_valid,
  output logic                     rd_hit,
  output logic                     collision,
  input  logic                     dump_start,
  output logic                     dump_busy,
  output logic signed [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0]        out_addr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  logic [1:0]               state;
  logic [ADDR_W-1:0]        ptr;
  logic                     rd_valid_q;
  logic                     core_rd_en;
  logic [ADDR_W-1:0]        core_rd_addr;
  logic signed [DATA_W-1:0] core_rd_data;
  logic                     core_rd_tag;

  assign dump_busy    = (state != ST_IDLE);
  assign core_rd_en   = dump_busy ? (state == ST_FETCH) : rd_en;
  assign core_rd_addr = dump_busy ? ptr : rd_addr;

  matrix_result_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_a   (wr_en_a),
    .wr_addr_a (wr_addr_a),
    .wr_data_a (wr_data_a),
    .wr_en_b   (wr_en_b),
    .wr_addr_b (wr_addr_b),
    .wr_data_b (wr_data_b),
    .clear     (clear),
    .rd_en     (core_rd_en),
    .rd_addr   (core_rd_addr),
    .rd_data   (core_rd_data),
    .rd_tag    (core_rd_tag),
    .collision (collision)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en && !dump_busy;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dump_start) begin
            state <= ST_FETCH;
            ptr   <= '0;
          end
        end
        ST_FETCH: state <= ST_SEND;
        ST_SEND: begin
          if (out_ready) begin
            // ptr wraps back to 0 after the last element.
            ptr   <= ptr + 1'b1;
            state <= (ptr == LAST_ADDR) ? ST_IDLE : ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The core read register is untouched during SEND, so the element holds
  // steady until the handshake; stale entries read back as zero.
  assign rd_valid  = rd_valid_q;
  assign rd_hit    = rd_valid_q & core_rd_tag;
  assign rd_data   = rd_hit ? core_rd_data : '0;
  assign out_valid = (state == ST_SEND);
  assign out_data  = (out_valid && core_rd_tag) ? core_rd_data : '0;
  assign out_addr  = ptr;
  assign out_last  = out_valid && (ptr == LAST_ADDR);

endmodule

// File: tb/tb_matrix_result_ram.sv
// Directed bench for matrix_result_ram: writes, collisions, read-first reads,
// clear, a full dump with a throttled sink, and reset in the middle of a dump.
module tb_matrix_result_ram;

  localparam int DATA_W = 19;
  localparam int ADDR_W = 6;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     wr_en_a, wr_en_b, clear, rd_en, dump_start, out_ready;
  logic [ADDR_W-1:0]        wr_addr_a, wr_addr_b, rd_addr;
  logic signed [DATA_W-1:0] wr_data_a, wr_data_b;
  logic signed [DATA_W-1:0] rd_data, out_data;
  logic                     rd_valid, rd_hit, collision, dump_busy, out_valid, out_last;
  logic [ADDR_W-1:0]        out_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  matrix_result_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_a    (wr_en_a),
    .wr_addr_a  (wr_addr_a),
    .wr_data_a  (wr_data_a),
    .wr_en_b    (wr_en_b),
    .wr_addr_b  (wr_addr_b),
    .wr_data_b  (wr_data_b),
    .clear      (clear),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_hit     (rd_hit),
    .collision  (collision),
    .dump_start (dump_start),
    .dump_busy  (dump_busy),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_d(input string tag, input logic [DATA_W-1:0] obs, input int exp);
    logic [DATA_W-1:0] e;
    e = DATA_W'(exp);
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input int addr, input int exp_data, input logic exp_hit, input string tag);
    rd_en = 1'b1; rd_addr = ADDR_W'(addr);
    step();
    rd_en = 1'b0;
    check({tag, "_valid"}, 32'(rd_valid), 32'(1));
    check({tag, "_hit"}, 32'(rd_hit), 32'(exp_hit));
    check_d({tag, "_data"}, rd_data, exp_data);
    $display("read  addr=%0d data=%0d hit=%0b", addr, $signed(rd_data), rd_hit);
  endtask

  task automatic idle_writes();
    wr_en_a = 1'b0; wr_en_b = 1'b0; clear = 1'b0;
  endtask

  initial begin
    int cnt;
    int cyc;
    rst_n = 1'b0; idle_writes(); rd_en = 1'b0; dump_start = 1'b0; out_ready = 1'b0;
    wr_addr_a = '0; wr_addr_b = '0; wr_data_a = '0; wr_data_b = '0; rd_addr = '0;

    // Outputs held at zero during reset, even with activity on the inputs.
    rd_en = 1'b1; dump_start = 1'b1;
    step(); step();
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_hit", 32'(rd_hit), 0);
    check_d("rst_rd_data", rd_data, 0);
    check("rst_collision", 32'(collision), 0);
    check("rst_dump_busy", 32'(dump_busy), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_last", 32'(out_last), 0);
    check_d("rst_out_data", out_data, 0);
    check("rst_out_addr", 32'(out_addr), 0);
    rd_en = 1'b0; dump_start = 1'b0;
    rst_n = 1'b1;
    step();

    do_read(5, 0, 1'b0, "post_rst_rd5");
    step();
    check("rd_valid_single_cycle", 32'(rd_valid), 0);

    // Two ports, different addresses.
    wr_en_a = 1'b1; wr_addr_a = 6'd3; wr_data_a = -19'sd7;
    wr_en_b = 1'b1; wr_addr_b = 6'd4; wr_data_b = 19'sd1000;
    step();
    idle_writes();
    check("no_collision", 32'(collision), 0);
    do_read(3, -7, 1'b1, "rd3");
    check("no_collision_later", 32'(collision), 0);
    do_read(4, 1000, 1'b1, "rd4");

    // Same-address dual write: B wins, collision pulses once.
    wr_en_a = 1'b1; wr_addr_a = 6'd9; wr_data_a = 19'sd11;
    wr_en_b = 1'b1; wr_addr_b = 6'd9; wr_data_b = 19'sd22;
    step();
    idle_writes();
    check("collision_pulse", 32'(collision), 1);
    step();
    check("collision_drop", 32'(collision), 0);
    do_read(9, 22, 1'b1, "rd9");

    // Read-first on a read-during-write.
    wr_en_a = 1'b1; wr_addr_a = 6'd2; wr_data_a = 19'sd5;
    step();
    wr_data_a = 19'sd6;
    do_read(2, 5, 1'b1, "rdw_old");
    idle_writes();
    do_read(2, 6, 1'b1, "rdw_new");
    wr_en_b = 1'b1; wr_addr_b = 6'd20; wr_data_b = 19'sd77;
    do_read(20, 0, 1'b0, "rdw_old_tag");
    idle_writes();
    do_read(20, 77, 1'b1, "rdw_new_tag");

    // Clear with a simultaneous write: the written entry survives.
    clear = 1'b1; wr_en_a = 1'b1; wr_addr_a = 6'd40; wr_data_a = -19'sd3;
    step();
    idle_writes();
    do_read(3, 0, 1'b0, "clr_rd3");
    do_read(40, -3, 1'b1, "clr_rd40");

    // Fill entry i with i-32 using both ports.
    for (int i = 0; i < 64; i += 2) begin
      wr_en_a = 1'b1; wr_addr_a = ADDR_W'(i);     wr_data_a = DATA_W'(i - 32);
      wr_en_b = 1'b1; wr_addr_b = ADDR_W'(i + 1); wr_data_b = DATA_W'(i - 31);
      step();
    end
    idle_writes();

    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    check("dump_busy_start", 32'(dump_busy), 1);
    cnt = 0; cyc = 0;
    while (cnt < 64 && cyc < 1000) begin
      out_ready = (cyc % 2 == 0);
      rd_en = 1'b1; rd_addr = ADDR_W'(cyc);
      dump_start = (cyc % 7 == 3);
      if (out_valid && out_ready) begin
        check("dump_addr", 32'(out_addr), 32'(cnt));
        check_d("dump_data", out_data, cnt - 32);
        check("dump_last", 32'(out_last), 32'(cnt == 63));
        $display("dump  addr=%0d data=%0d last=%0b", out_addr, $signed(out_data), out_last);
        cnt++;
      end
      step();
      check("rd_ignored_in_dump", 32'(rd_valid), 0);
      cyc++;
    end
    rd_en = 1'b0; dump_start = 1'b0; out_ready = 1'b0;
    check("dump_count", 32'(cnt), 32'(64));
    check("dump_busy_end", 32'(dump_busy), 0);
    check("out_valid_end", 32'(out_valid), 0);
    step();
    check("dump_no_restart", 32'(dump_busy), 0);

    // Reset in the middle of a dump at element 10.
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (!(out_valid && out_addr == 6'd10) && cyc < 200) begin
      step();
      cyc++;
    end
    check("reach_elem10", 32'(out_valid && out_addr == 6'd10), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_dump_busy", 32'(dump_busy), 0);
    out_ready = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_idle", 32'(dump_busy), 0);
    do_read(0, 0, 1'b0, "post_rst_rd0");
    do_read(63, 0, 1'b0, "post_rst_rd63");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
